// File: rtl/fads_sort_scheduler.sv
// Timed sort-pulse scheduler: timestamps droplet requests, queues their due times and
// fires one shaped trigger pulse per droplet. Optional holdoff state: FADS_SCHED_HOLDOFF_EN.
module fads_sort_scheduler #(
  parameter int AW = 3,
  parameter int TW = 32
) (
  input  logic          adc_clk_i,
  input  logic          adc_rst_i,
  input  logic          enable_i,
  input  logic          req_i,
  input  logic          flush_i,
  input  logic [TW-1:0] delay_i,
  input  logic [TW-1:0] duration_i,
  input  logic [15:0]   holdoff_i,
  output logic          sort_trig_o,
  output logic          busy_o,
  output logic [AW:0]   level_o,
  output logic [TW-1:0] fire_cnt_o,
  output logic [TW-1:0] drop_cnt_o,
  output logic [TW-1:0] late_cnt_o
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PULSE   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  state_t        state_r;
  logic [TW-1:0] now_r;
  logic [TW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   level_r;
  logic [TW-1:0] pulse_cnt_r;
  logic          trig_r;
  logic          busy_r;
  logic [TW-1:0] fire_cnt_r;
  logic [TW-1:0] drop_cnt_r;
  logic [TW-1:0] late_cnt_r;
`ifdef FADS_SCHED_HOLDOFF_EN
  logic [15:0]   hold_cnt_r;
`else
  logic [15:0]   unused_holdoff_s;
  assign unused_holdoff_s = holdoff_i;
`endif

  logic [TW-1:0] head_age_s;
  logic [TW-1:0] dur_s;
  logic          empty_s;
  logic          full_s;
  logic          req_s;
  logic          pop_s;
  logic          push_s;
  logic          drop_s;
  logic [AW:0]   level_nxt_s;

  // Age of the head entry; its sign bit is the wrap-safe "not yet due" flag.
  assign head_age_s = now_r - mem_r[rd_ptr_r];
  assign empty_s    = (level_r == (AW+1)'(0));
  assign full_s     = (level_r == (AW+1)'(DEPTH));

  // Queue push/pop/drop decisions and the next fill level.
  always_comb begin
    req_s       = req_i & enable_i & ~flush_i;
    pop_s       = (state_r == ST_IDLE) & ~empty_s & ~head_age_s[TW-1] & ~flush_i;
    push_s      = req_s & (~full_s | pop_s);
    drop_s      = req_s & full_s & ~pop_s;
    dur_s       = (duration_i == '0) ? TW'(1) : duration_i;
    level_nxt_s = level_r;
    if (flush_i) begin
      level_nxt_s = (AW+1)'(0);
    end else if (push_s && !pop_s) begin
      level_nxt_s = level_r + (AW+1)'(1);
    end else if (pop_s && !push_s) begin
      level_nxt_s = level_r - (AW+1)'(1);
    end else begin
      level_nxt_s = level_r;
    end
  end

  // Free-running timebase.
  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i) begin
      now_r <= '0;
    end else begin
      now_r <= now_r + TW'(1);
    end
  end

  // Due-time storage.
  always_ff @(posedge adc_clk_i) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= now_r + delay_i;
    end
  end

  // Queue pointers and level.
  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else if (flush_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      level_r <= level_nxt_s;
    end
  end

  // Event counters; only reset clears them.
  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i) begin
      fire_cnt_r <= '0;
      drop_cnt_r <= '0;
      late_cnt_r <= '0;
    end else begin
      if (pop_s) begin
        fire_cnt_r <= fire_cnt_r + TW'(1);
      end
      if (pop_s && (head_age_s != '0)) begin
        late_cnt_r <= late_cnt_r + TW'(1);
      end
      if (drop_s) begin
        drop_cnt_r <= drop_cnt_r + TW'(1);
      end
    end
  end

  // Pulse FSM with registered trigger and busy flags.
  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i) begin
      state_r     <= ST_IDLE;
      trig_r      <= 1'b0;
      busy_r      <= 1'b0;
      pulse_cnt_r <= '0;
`ifdef FADS_SCHED_HOLDOFF_EN
      hold_cnt_r  <= 16'd0;
`endif
    end else if (flush_i) begin
      state_r <= ST_IDLE;
      trig_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            state_r     <= ST_PULSE;
            trig_r      <= 1'b1;
            busy_r      <= 1'b1;
            pulse_cnt_r <= dur_s;
          end else begin
            busy_r <= (level_nxt_s != (AW+1)'(0));
          end
        end
        ST_PULSE: begin
          if (pulse_cnt_r <= TW'(1)) begin
            trig_r     <= 1'b0;
`ifdef FADS_SCHED_HOLDOFF_EN
            state_r    <= ST_HOLDOFF;
            hold_cnt_r <= holdoff_i;
            busy_r     <= 1'b1;
`else
            state_r    <= ST_IDLE;
            busy_r     <= (level_nxt_s != (AW+1)'(0));
`endif
          end else begin
            pulse_cnt_r <= pulse_cnt_r - TW'(1);
            busy_r      <= 1'b1;
          end
        end
        ST_HOLDOFF: begin
          trig_r <= 1'b0;
`ifdef FADS_SCHED_HOLDOFF_EN
          if (hold_cnt_r <= 16'd1) begin
            state_r <= ST_IDLE;
            busy_r  <= (level_nxt_s != (AW+1)'(0));
          end else begin
            hold_cnt_r <= hold_cnt_r - 16'd1;
            busy_r     <= 1'b1;
          end
`else
          state_r <= ST_IDLE;
          busy_r  <= (level_nxt_s != (AW+1)'(0));
`endif
        end
        default: begin
          state_r <= ST_IDLE;
          trig_r  <= 1'b0;
          busy_r  <= (level_nxt_s != (AW+1)'(0));
        end
      endcase
    end
  end

  assign sort_trig_o = trig_r;
  assign busy_o      = busy_r;
  assign level_o     = level_r;
  assign fire_cnt_o  = fire_cnt_r;
  assign drop_cnt_o  = drop_cnt_r;
  assign late_cnt_o  = late_cnt_r;

endmodule

// File: tb/tb_fads_sort_scheduler.sv
// Bench for fads_sort_scheduler: directed scenarios plus random traffic, all checked
// every cycle against an event-level schedule model (due times in absolute cycles).
module tb_fads_sort_scheduler;

`ifdef FADS_SCHED_HOLDOFF_EN
  localparam bit HEN = 1'b1;
`else
  localparam bit HEN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        en;
  logic        req;
  logic        flush;
  logic [31:0] delay;
  logic [31:0] dur;
  logic [15:0] hold;
  logic        trig;
  logic        busy;
  logic [3:0]  level;
  logic [31:0] fire;
  logic [31:0] drop;
  logic [31:0] late;

  logic        s_req;
  logic [7:0]  s_delay;
  logic [7:0]  s_dur;
  logic        s_trig;
  logic        s_busy;
  logic [2:0]  s_level;
  logic [7:0]  s_fire;
  logic [7:0]  s_drop;
  logic [7:0]  s_late;

  fads_sort_scheduler #(.AW(3), .TW(32)) u_dut (
    .adc_clk_i(clk), .adc_rst_i(rst), .enable_i(en), .req_i(req), .flush_i(flush),
    .delay_i(delay), .duration_i(dur), .holdoff_i(hold),
    .sort_trig_o(trig), .busy_o(busy), .level_o(level),
    .fire_cnt_o(fire), .drop_cnt_o(drop), .late_cnt_o(late)
  );

  // Narrow timebase instance: its 8-bit counter wraps within a few hundred cycles.
  fads_sort_scheduler #(.AW(2), .TW(8)) u_small (
    .adc_clk_i(clk), .adc_rst_i(rst), .enable_i(1'b1), .req_i(s_req), .flush_i(1'b0),
    .delay_i(s_delay), .duration_i(s_dur), .holdoff_i(16'd0),
    .sort_trig_o(s_trig), .busy_o(s_busy), .level_o(s_level),
    .fire_cnt_o(s_fire), .drop_cnt_o(s_drop), .late_cnt_o(s_late)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run;
  int tests_failed;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: queue of absolute due cycles and the predicted pulse window.
  longint cyc;
  longint mq[$];
  longint next_free;
  longint trig_lo;
  longint trig_hi;
  longint m_fire;
  longint m_drop;
  longint m_late;
  longint r2;

  task automatic model_reset();
    cyc = 0;
    mq.delete();
    next_free = 0;
    trig_lo = 1;
    trig_hi = 0;
    m_fire = 0;
    m_drop = 0;
    m_late = 0;
  endtask

  task automatic model_step();
    longint due;
    longint d;
    bit     pop;
    if (flush) begin
      mq.delete();
      next_free = cyc + 1;
      if (trig_hi > cyc) trig_hi = cyc;
    end else begin
      pop = (mq.size() > 0) && (mq[0] <= cyc) && (cyc >= next_free);
      if (pop) begin
        due = mq.pop_front();
        d = (dur == 0) ? 1 : longint'(dur);
        trig_lo = cyc + 1;
        trig_hi = cyc + d;
        next_free = cyc + d + 1 + (HEN ? ((hold == 0) ? 1 : longint'(hold)) : 0);
        m_fire++;
        if (cyc > due) m_late++;
      end
      if (req && en) begin
        if (mq.size() < 8) mq.push_back(cyc + longint'(delay));
        else m_drop++;
      end
    end
  endtask

  task automatic check_outputs();
    check("trig", trig, (cyc >= trig_lo) && (cyc <= trig_hi));
    check("level", level, mq.size());
    check("busy", busy, (cyc < next_free) || (mq.size() != 0));
    check("fire_cnt", fire, m_fire[31:0]);
    check("drop_cnt", drop, m_drop[31:0]);
    check("late_cnt", late, m_late[31:0]);
  endtask

  task automatic tick();
    check_outputs();
    model_step();
    @(negedge clk);
    cyc++;
    req = 1'b0;
    s_req = 1'b0;
    flush = 1'b0;
  endtask

  task automatic run_to(input longint t);
    while (cyc < t) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 1'b0;
    s_req = 1'b0;
    flush = 1'b0;
    en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    delay = 32'd10;
    dur = 32'd1;
    hold = 16'd0;
    s_delay = 8'd50;
    s_dur = 8'd3;
    do_reset();

    // Reset state, single droplet and timebase wrap on the narrow instance.
    check("rst_trig", trig, 1'b0);
    check("rst_level", level, 4'd0);
    delay = 32'd100; dur = 32'd125; req = 1'b1;
    tick();
    run_to(100); check("single_pre", trig, 1'b0);
    tick();      check("single_rise", trig, 1'b1);
    run_to(225); check("single_last", trig, 1'b1);
    tick();      check("single_fall", trig, 1'b0);
    run_to(236); s_req = 1'b1;
    tick();
    run_to(286); check("wrap_pre", s_trig, 1'b0);
    tick();      check("wrap_rise", s_trig, 1'b1);
    run_to(289); check("wrap_last", s_trig, 1'b1);
    tick();      check("wrap_fall", s_trig, 1'b0);
    run_to(300);
    check("single_fire", fire, 32'd1);
    check("single_late", late, 32'd0);
    check("wrap_fire", s_fire, 8'd1);
    check("wrap_late", s_late, 8'd0);

    // Overlapping requests serialised behind the first pulse.
    do_reset();
    delay = 32'd50; dur = 32'd40; hold = 16'd10; req = 1'b1;
    tick();
    run_to(5); req = 1'b1;
    tick();
    r2 = 91 + (HEN ? 11 : 1);
    run_to(r2 - 1); check("ovl_gap", trig, 1'b0);
    tick();         check("ovl_rise2", trig, 1'b1);
    check("ovl_late", late, 32'd1);
    run_to(200);    check("ovl_fire", fire, 32'd2);

    // Overflow: ten requests into an eight-entry queue.
    do_reset();
    delay = 32'd1000; dur = 32'd2; hold = 16'd0;
    for (int i = 0; i < 10; i++) begin
      req = 1'b1;
      tick();
    end
    tick();
    check("ovf_level", level, 4'd8);
    check("ovf_drop", drop, 32'd2);
    run_to(1100);
    check("ovf_fire", fire, 32'd8);
    check("ovf_empty", level, 4'd0);
    check("ovf_idle", busy, 1'b0);

    // Flush mid-pulse with three entries queued, plus a discarded same-cycle request.
    do_reset();
    delay = 32'd20; dur = 32'd30;
    for (int i = 0; i < 4; i++) begin
      req = 1'b1;
      tick();
    end
    run_to(30);
    check("flush_pre_trig", trig, 1'b1);
    check("flush_pre_level", level, 4'd3);
    flush = 1'b1; req = 1'b1;
    tick();
    check("flush_trig", trig, 1'b0);
    check("flush_level", level, 4'd0);
    check("flush_fire", fire, 32'd1);
    check("flush_drop", drop, 32'd0);
    run_to(80);
    check("flush_quiet", fire, 32'd1);

    // Asynchronous reset in the middle of a pulse.
    do_reset();
    delay = 32'd5; dur = 32'd20; req = 1'b1;
    tick();
    run_to(10);
    check("arst_pre", trig, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("arst_trig", trig, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_fire", fire, 32'd0);
    do_reset();

    // Disabled requests and zero duration.
    en = 1'b0; req = 1'b1; delay = 32'd3;
    tick();
    tick();
    check("dis_level", level, 4'd0);
    check("dis_drop", drop, 32'd0);
    en = 1'b1;
    run_to(5); dur = 32'd0; req = 1'b1;
    tick();
    run_to(9); check("dur0_hi", trig, 1'b1);
    tick();    check("dur0_lo", trig, 1'b0);
    check("dur0_fire", fire, 32'd1);

    // Random traffic with changing delay/duration and occasional flushes.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      en = ($urandom % 8) != 0;
      req = ($urandom % 6) == 0;
      flush = ($urandom % 300) == 0;
      delay = $urandom_range(80, 2);
      dur = $urandom_range(12, 0);
      if ((cyc >= next_free) && (($urandom % 16) == 0)) hold = 16'($urandom_range(6, 0));
      tick();
    end
    req = 1'b0;
    for (int i = 0; i < 400; i++) tick();
    check("rand_drained", level, 4'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fads_sort_scheduler.md
# fads_sort_scheduler

Timed sort-pulse scheduler between the FADS droplet detector and the ASG/high-voltage trigger. Each positive-droplet request is timestamped, delayed by the detection-to-junction travel time, and queued in a small FIFO. The block issues one shaped `sort_trig_o` pulse per queued droplet at its due time. It serialises overlapping requests so the single electrode driver is never double-driven.

## Interface
- `AW`, 3: FIFO address width; depth = 2^AW entries.
- `TW`, 32: timestamp, delay and duration width.
- `adc_clk_i`  in  1: ADC clock; the only clock.
- `adc_rst_i`  in  1: reset, asynchronous, active-high.
- `enable_i`  in  1: when low, `req_i` is ignored. Queued entries still drain.
- `req_i`  in  1: single-cycle sort request from the detector evaluation state.
- `flush_i`  in  1: synchronous clear of the queue and any active pulse.
- `delay_i`  in  TW: travel delay in cycles. Legal range is 2 … 2^(TW-1)-1.
- `duration_i`  in  TW: pulse width in cycles. A value of 0 is treated as 1.
- `holdoff_i`  in  16: minimum low time between pulses, in cycles.
- `sort_trig_o`  out  1: sort pulse to the ASG trigger.
- `busy_o`  out  1: high when the FSM is not IDLE or the queue is non-empty.
- `level_o`  out  AW+1: number of queued entries, 0 … 2^AW.
- `fire_cnt_o`  out  TW: number of pulses issued.
- `drop_cnt_o`  out  TW: number of requests lost because the queue was full.
- `late_cnt_o`  out  TW: number of pulses started after their due time.

## Operation
- **Timebase.** A free-running TW-bit counter `now` increments every cycle and wraps.
- **Enqueue.**
  - When `req_i & enable_i` and the queue is not full, write `due = now + delay_i` (mod 2^TW).
  - When the queue is full, discard the request and increment `drop_cnt_o`.
- **Due test.** The head entry is due when `$signed(now - due) >= 0`. This comparison is wrap-safe within the legal delay range.
- **FSM: IDLE, PULSE, HOLDOFF.**
  - IDLE → PULSE when the queue is non-empty and the head is due.
    - Pop the head.
    - Latch `max(duration_i, 1)` into the pulse counter.
    - Increment `fire_cnt_o`.
    - If `now - due > 0`, also increment `late_cnt_o`.
  - PULSE: `sort_trig_o` is high. Decrement the pulse counter; at 1, go to HOLDOFF.
  - HOLDOFF: `sort_trig_o` is low. Count `holdoff_i` cycles, then go to IDLE. With `holdoff_i` = 0, go to IDLE on the next cycle.
- **Late droplets.** A droplet whose due time passes during PULSE or HOLDOFF fires at the first IDLE opportunity. It is counted late and is never skipped.
- **Same-cycle push and pop** are both performed. `level_o` is unchanged, and a full queue accepts the push in that case.
- **Mid-operation configuration changes.**
  - `delay_i` changes affect only subsequent requests.
  - `duration_i` is sampled only at pop.
  - `holdoff_i` is sampled on entry to HOLDOFF.
- **`flush_i`** empties the queue, forces IDLE and drives `sort_trig_o` low on the next edge. Counters are retained. A `req_i` in the same cycle is discarded and not counted.
- **Counters** wrap at 2^TW and are cleared only by reset.

## Timing
- **Reset (asynchronous, active-high):**
  - `sort_trig_o` = 0, `busy_o` = 0, `level_o` = 0.
  - All counters = 0, `now` = 0, FSM = IDLE, queue empty.
  - Reset asserted mid-pulse drops `sort_trig_o` immediately, without waiting for a clock edge.
- **Outputs:** all are registered; there is no combinational path from inputs to outputs.
- **Latency:** with the block idle and the queue empty, `req_i` sampled high at cycle t makes `sort_trig_o` rise at cycle t+D+1 (D = `delay_i`). The pulse then stays high for `duration_i` cycles.
- **Queue level:** `level_o` updates one cycle after the push or pop edge.
- **Throughput:** back-to-back pulses are separated by at least `holdoff_i`+1 low cycles; with the holdoff feature compiled out, by 1 low cycle.

## Configuration
- Macro `FADS_SCHED_HOLDOFF_EN`.
- **Defined:** the HOLDOFF state and `holdoff_i` operate as described above.
- **Undefined:** PULSE → IDLE directly, `holdoff_i` is ignored, and the gap between pulses is exactly 1 cycle.

## Test plan
- **Single droplet:** delay 100, duration 125, one `req_i` at t0 → `sort_trig_o` high for cycles t0+101 … t0+225; `fire_cnt_o` = 1, `late_cnt_o` = 0.
- **Overlap:** delay 50, duration 40, holdoff 10, requests 5 cycles apart → second pulse starts at first fall + 11 cycles; `late_cnt_o` = 1.
- **Overflow:** AW = 3, delay 1000, 10 requests → `level_o` = 8, `drop_cnt_o` = 2, then exactly 8 pulses are issued.
- **Wrap:** force `now` to 2^32-20, delay 50 → pulse rises 51 cycles after `req_i`, and is not counted late.
- **Flush and reset:** `flush_i` mid-pulse with 3 entries queued → `sort_trig_o` low next cycle, `level_o` = 0, `fire_cnt_o` unchanged. Async `adc_rst_i` mid-pulse → `sort_trig_o` low without a clock edge.
- **Disable and duration 0:** `enable_i` = 0 with `req_i` → no enqueue and no drop. Duration 0 → 1-cycle pulse.
